seqgen: RTL and testbench
=========================

Name: seqgen

Overview:
- Serial pattern transmitter: the producing end of the serial bit-stream that the sequence detector consumes.
- Captures a PAT_W-bit pattern on a start request and shifts it out MSB-first, one bit per clk.
- Repeats the pattern a programmable number of frames, with an optional idle gap between frames.
- Provides busy/done handshake; sits upstream of the detector in bench loopbacks and in stimulus paths.

Parameters:
- PAT_W, 5, pattern length in bits (>=2).
- CNT_W, 4, width of the repeat-count input.
- GAP_W, 3, width of the inter-frame gap input.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when state==IDLE.
- pattern  in  PAT_W  pattern, captured on accepted start.
- repeat_n  in  CNT_W  frames to send; 0 treated as 1.
- gap  in  GAP_W  idle cycles between frames; captured on accepted start.
- stop  in  1  abort request.
- out  out  1  serial data bit.
- out_valid  out  1  out carries a pattern or parity bit this cycle.
- busy  out  1  high from cycle after accepted start through DONE.
- done  out  1  one-cycle completion pulse.
- state  out  3  current FSM state code (debug visibility).

Behaviour:
- All outputs registered.
- Reset (rst=1 at posedge): state=IDLE, out=0, out_valid=0, busy=0, done=0; shift register, bit counter, frame counter and gap counter cleared. Reset mid-frame aborts immediately with no done pulse.
- States:
  - IDLE=0: out=0, out_valid=0. On start: latch pattern into shadow and shift registers, frames=max(repeat_n,1), gap; next state SEND.
  - SEND=1: out=shift[PAT_W-1], out_valid=1; shift left each cycle, bitcnt counts 0..PAT_W-1.
  - PARITY=2: see Optional Feature.
  - GAP=3: out=0, out_valid=0 for exactly gap cycles.
  - DONE=4: done=1, busy=1, out_valid=0; next state IDLE.
- Latency: start sampled at cycle t gives the first bit (pattern MSB) on out at t+1.
- End of frame (bitcnt==PAT_W-1, or the parity bit when enabled):
  - frames>1 and gap>0: go to GAP, decrement frames.
  - frames>1 and gap==0: reload the shift register from the shadow register and stay in SEND. The next frame follows back-to-back with no bubble.
  - frames==1: go to DONE.
- GAP exit: after gap cycles, reload from shadow and go to SEND.
- Frame counter decrements exactly once per completed frame and never underflows.
- stop sampled high in SEND, PARITY or GAP: the bit currently on out is the last driven; next state DONE and done still pulses. stop in IDLE or DONE is ignored.
- start while not IDLE is ignored. It is not queued. Pattern, gap and repeat_n changes while busy have no effect.
- start and stop high together in IDLE: start accepted, stop ignored.
- Minimum idle-to-idle for one frame, no parity: PAT_W+2 cycles after start.

Optional Feature:
- Macro SEQGEN_PARITY_EN.
- Defined: after the last pattern bit of every frame, state PARITY drives one extra bit with out_valid=1. That bit is the XOR-reduction of the captured pattern (even parity). Frame length is PAT_W+1, and end-of-frame decisions occur after the parity bit. stop in PARITY terminates after the parity bit.
- Undefined: PARITY state and logic are absent; frames are PAT_W bits.

Decomposition:
- Package seqgen_pkg holds the state encodings (IDLE, SEND, PARITY, GAP, DONE), the 3-bit state width, and the default PAT_W/CNT_W/GAP_W constants.
- One natural sub-module: seqgen_shreg, a loadable PAT_W-bit shift register with shadow copy, reload strobe and bit counter, with a last-bit flag.
- FSM and counters stay in seqgen.

Test Plan:
- Single frame: rst then start with pattern=5'b10010, repeat_n=1, gap=0 -> out 1,0,0,1,0 with out_valid=1 on cycles t+1..t+5, done=1 at t+6, IDLE at t+7.
- Back-to-back frames: pattern=5'b10010, repeat_n=3, gap=0 -> 15 contiguous valid bits "100101001010010"; out looped to the detector (in) gives detector out pulses at bits 5, 10 and 15.
- Gapped frames: repeat_n=2, gap=3 -> 5 valid bits, 3 cycles out_valid=0 with out=0, 5 valid bits, then done; start mid-run is ignored.
- repeat_n=0 -> behaves exactly as repeat_n=1, a single frame.
- Abort: stop asserted on the 3rd bit of frame 1 of 4 -> 3 valid bits total, done pulse next cycle, no further valid bits; rst asserted mid-frame in a second run -> IDLE next cycle, no done.
- SEQGEN_PARITY_EN defined, pattern=5'b10010 -> 6 valid bits 1,0,0,1,0,0; with pattern=5'b10110 -> trailing parity bit 1.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared definitions for the seqgen serial pattern transmitter.
package seqgen_pkg;

  localparam int unsigned StateW  = 3;
  localparam int unsigned DefPatW = 5;
  localparam int unsigned DefCntW = 4;
  localparam int unsigned DefGapW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StSend   = 3'd1,
    StParity = 3'd2,
    StGap    = 3'd3,
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/seqgen_shreg.sv
// Loadable MSB-first shift register with a shadow copy for frame reloads and a bit counter.
module seqgen_shreg #(
  parameter int unsigned PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             reload,
  input  logic             shift,
  output logic             msb_next,
  output logic             last
);

  localparam int unsigned BcW = $clog2(PAT_W);

  logic [PAT_W-1:0] shadow_q, shadow_d;
  logic [PAT_W-1:0] shift_q, shift_d;
  logic [BcW-1:0]   bitcnt_q, bitcnt_d;

  always_comb begin
    shadow_d = shadow_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (load) begin
      shadow_d = pattern;
      shift_d  = pattern;
      bitcnt_d = '0;
    end else if (reload) begin
      shift_d  = shadow_q;
      bitcnt_d = '0;
    end else if (shift) begin
      shift_d  = {shift_q[PAT_W-2:0], 1'b0};
      bitcnt_d = bitcnt_q + BcW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Lets the parent register the bit that will be on the line next cycle.
  assign msb_next = shift_d[PAT_W-1];
  assign last     = (bitcnt_q == BcW'(PAT_W - 1));

endmodule

// File: rtl/seqgen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for N frames with optional gaps.
// Define SEQGEN_PARITY_EN to append an even-parity bit to every frame.
module seqgen
  import seqgen_pkg::*;
#(
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned GAP_W = DefGapW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [CNT_W-1:0]  repeat_n,
  input  logic [GAP_W-1:0]  gap,
  input  logic              stop,
  output logic              out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [StateW-1:0] state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, reload, shift, frame_end;
  logic             msb_next, last;
`ifdef SEQGEN_PARITY_EN
  logic             parity_q, parity_d;
`endif

  seqgen_shreg #(
    .PAT_W(PAT_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .pattern  (pattern),
    .reload   (reload),
    .shift    (shift),
    .msb_next (msb_next),
    .last     (last)
  );

  always_comb begin
    state_d   = state_q;
    frames_d  = frames_q;
    gap_d     = gap_q;
    gapcnt_d  = gapcnt_q;
    load      = 1'b0;
    reload    = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
`ifdef SEQGEN_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load     = 1'b1;
          frames_d = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
          gap_d    = gap;
          state_d  = StSend;
`ifdef SEQGEN_PARITY_EN
          parity_d = ^pattern;
`endif
        end
      end
      StSend: begin
        if (stop) begin
          state_d = StDone;
        end else if (last) begin
`ifdef SEQGEN_PARITY_EN
          state_d = StParity;
`else
          frame_end = 1'b1;
`endif
        end else begin
          shift = 1'b1;
        end
      end
`ifdef SEQGEN_PARITY_EN
      StParity: begin
        if (stop) state_d = StDone;
        else      frame_end = 1'b1;
      end
`endif
      StGap: begin
        if (stop) begin
          state_d = StDone;
        end else if (gapcnt_q <= GAP_W'(1)) begin
          reload  = 1'b1;
          state_d = StSend;
        end else begin
          gapcnt_d = gapcnt_q - GAP_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // frames_q is never decremented on the final frame, so it cannot underflow.
    if (frame_end) begin
      if (frames_q > CNT_W'(1)) begin
        frames_d = frames_q - CNT_W'(1);
        if (gap_q != '0) begin
          state_d  = StGap;
          gapcnt_d = gap_q;
        end else begin
          reload  = 1'b1;
          state_d = StSend;
        end
      end else begin
        state_d = StDone;
      end
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    out_d   = 1'b0;
    valid_d = 1'b0;
    if (state_d == StSend) begin
      out_d   = msb_next;
      valid_d = 1'b1;
    end
`ifdef SEQGEN_PARITY_EN
    if (state_d == StParity) begin
      out_d   = parity_d;
      valid_d = 1'b1;
    end
`endif
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      frames_q <= '0;
      gap_q    <= '0;
      gapcnt_q <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      gapcnt_q <= gapcnt_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SEQGEN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_seqgen.sv
// Directed self-checking bench for seqgen; frame expectations follow SEQGEN_PARITY_EN.
module tb_seqgen;
  import seqgen_pkg::*;

  localparam int unsigned PW = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned GW = 3;
`ifdef SEQGEN_PARITY_EN
  localparam int FL = 6;
  localparam logic [FL-1:0]   FRAME_A = 6'b100100;  // 10010 + even parity 0
  localparam logic [FL-1:0]   FRAME_B = 6'b101101;  // 10110 + even parity 1
  localparam logic [3*FL-1:0] B2B     = 18'b100100100100100100;
`else
  localparam int FL = 5;
  localparam logic [FL-1:0]   FRAME_A = 5'b10010;
  localparam logic [FL-1:0]   FRAME_B = 5'b10110;
  localparam logic [3*FL-1:0] B2B     = 15'b100101001010010;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [PW-1:0] pattern;
  logic [CW-1:0] repeat_n;
  logic [GW-1:0] gap;
  logic          out, out_valid, busy, done;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  seqgen #(
    .PAT_W(PW),
    .CNT_W(CW),
    .GAP_W(GW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .repeat_n  (repeat_n),
    .gap       (gap),
    .stop      (stop),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns at the first cycle of the frame (first bit on out).
  task automatic kick(input logic [PW-1:0] p, input logic [CW-1:0] r, input logic [GW-1:0] g);
    pattern  = p;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pattern = '0; repeat_n = '0; gap = '0;
    step();
    step();
    checks++;
    if ({state, out, out_valid, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset: state=%0d out=%b valid=%b busy=%b done=%b, want all 0",
               state, out, out_valid, busy, done);
    end
    rst = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (state !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_stop: state=%0d done=%b, want state=0 done=0", state, done);
    end
  endtask

  task automatic test_single_frame();
    logic [FL-1:0] got, gv;
    kick(5'b10010, 4'd1, 3'd0);
    for (int i = 0; i < FL; i++) begin
      got = {got[FL-2:0], out};
      gv  = {gv[FL-2:0], out_valid};
      step();
    end
    checks++;
    if (got !== FRAME_A) begin
      errors++; $display("FAIL single_bits: got %b, want %b", got, FRAME_A);
    end
    checks++;
    if (gv !== '1) begin
      errors++; $display("FAIL single_valid: got %b, want all 1", gv);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || state !== 3'd4) begin
      errors++;
      $display("FAIL single_done: done=%b busy=%b valid=%b state=%0d, want 1 1 0 4",
               done, busy, out_valid, state);
    end
    step();
    checks++;
    if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: state=%0d done=%b busy=%b, want 0 0 0", state, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3*FL-1:0] got, gv;
`ifndef SEQGEN_PARITY_EN
    logic [PW-1:0] win;
    int            hits;
    win  = '0;
    hits = 0;
`endif
    kick(5'b10010, 4'd3, 3'd0);
    for (int i = 0; i < 3 * FL; i++) begin
      got = {got[3*FL-2:0], out};
      gv  = {gv[3*FL-2:0], out_valid};
`ifndef SEQGEN_PARITY_EN
      // Detector-style sliding window over the received stream.
      win = {win[PW-2:0], out};
      if (i >= PW - 1 && win == 5'b10010) hits++;
`endif
      step();
    end
    checks++;
    if (got !== B2B) begin
      errors++; $display("FAIL b2b_bits: got %b, want %b", got, B2B);
    end
    checks++;
    if (gv !== '1) begin
      errors++; $display("FAIL b2b_valid: got %b, want all 1", gv);
    end
`ifndef SEQGEN_PARITY_EN
    checks++;
    if (hits !== 3) begin
      errors++; $display("FAIL b2b_detect: got %0d matches, want 3", hits);
    end
`endif
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: done=%b, want 1", done);
    end
    step();
  endtask

  task automatic test_gapped();
    logic [2*FL+2:0] got, gv;
    kick(5'b10010, 4'd2, 3'd3);
    for (int i = 0; i < 2 * FL + 3; i++) begin
      // A second start while busy must be ignored, including its new pattern/gap/count.
      if (i == 2) begin
        pattern = 5'b01111; gap = 3'd0; repeat_n = 4'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == FL + 1) begin
        checks++;
        if (state !== 3'd3) begin
          errors++; $display("FAIL gap_state: state=%0d, want 3", state);
        end
      end
      got = {got[2*FL+1:0], out};
      gv  = {gv[2*FL+1:0], out_valid};
      step();
    end
    start = 1'b0;
    checks++;
    if (got !== {FRAME_A, 3'b000, FRAME_A}) begin
      errors++; $display("FAIL gap_bits: got %b, want %b", got, {FRAME_A, 3'b000, FRAME_A});
    end
    checks++;
    if (gv !== {{FL{1'b1}}, 3'b000, {FL{1'b1}}}) begin
      errors++; $display("FAIL gap_valid: got %b, want %b", gv, {{FL{1'b1}}, 3'b000, {FL{1'b1}}});
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL gap_done: done=%b, want 1", done);
    end
    step();
    checks++;
    if (state !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL gap_idle: state=%0d valid=%b, want 0 0", state, out_valid);
    end
  endtask

  task automatic test_repeat_zero();
    logic [FL-1:0] got;
    kick(5'b10110, 4'd0, 3'd2);
    for (int i = 0; i < FL; i++) begin
      got = {got[FL-2:0], out};
      step();
    end
    checks++;
    if (got !== FRAME_B) begin
      errors++; $display("FAIL rep0_bits: got %b, want %b", got, FRAME_B);
    end
    checks++;
    if (done !== 1'b1 || state !== 3'd4) begin
      errors++; $display("FAIL rep0_done: done=%b state=%0d, want 1 4", done, state);
    end
    step();
  endtask

  task automatic test_abort();
    int nvalid;
    int nextra;
    nvalid = 0;
    nextra = 0;
    kick(5'b11011, 4'd4, 3'd0);
    for (int i = 0; i < 3; i++) begin
      if (out_valid) nvalid++;
      if (i == 2) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_done: done=%b valid=%b, want 1 0", done, out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) nextra++;
    end
    checks++;
    if (nvalid !== 3 || nextra !== 0) begin
      errors++;
      $display("FAIL abort_count: valid bits=%0d then %0d, want 3 then 0", nvalid, nextra);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL abort_idle: state=%0d, want 0", state);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    kick(5'b10010, 4'd2, 3'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({state, out, out_valid, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid: state=%0d out=%b valid=%b busy=%b done=%b, want all 0",
               state, out, out_valid, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      if (done || out_valid) ndone++;
      step();
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL rst_quiet: %0d cycles with done/valid, want 0", ndone);
    end
  endtask

  task automatic test_start_stop();
    pattern = 5'b10010; repeat_n = 4'd1; gap = 3'd0;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (state !== 3'd1 || out_valid !== 1'b1 || out !== 1'b1) begin
      errors++;
      $display("FAIL start_stop: state=%0d valid=%b out=%b, want 1 1 1", state, out_valid, out);
    end
    for (int i = 0; i < FL; i++) step();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL start_stop_done: done=%b, want 1", done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_repeat_zero();
    test_abort();
    test_reset_mid();
    test_start_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
